sao_ctu_sched: RTL and testbench
================================

// Module: sao_ctu_sched
// PURPOSE
//  Single-clock CTU scheduler for SAO. Sequences the statistics phase (per-component pixel-beat count)
//  and the offset-decision phase (per-component, clock-enable paced) of consecutive CTUs.
//  Decision of CTU n overlaps statistics of CTU n+1, with a wait_forPre stall when decision lags.
//  Generalises the two-clock slow/fast arrangement to one clock plus a programmable slow enable,
//  parametrised component count, CTB size and beat width.
// PARAMETERS
//  N_PIX         8   pixels consumed per statistics beat (power of 2)
//  N_COMP        3   components per CTU (1 = monochrome; 3 = 4:2:0 Y/Cb/Cr)
//  MIN_CTB_LOG2  4   smallest CTB size, log2
//  MAX_CTB_LOG2  6   largest CTB size, log2
//  CNT_ST_LEN    10  cnt_st width; must hold 2^(2*MAX_CTB_LOG2)/N_PIX-1
//  CNT_DC_LEN    6   cnt_dc width
//  DC_CYCLES     36  slow-enable strobes per component in decision
//  SLOW_DIV_LEN  3   slow_div width
// PORTS
//  clk            in   1             system clock
//  arst           in   1             async reset, active-high
//  start_ctu      in   1             request new CTU; accepted only when start_rdy=1
//  ctb_size_log2  in   3             CTB size, latched on accept
//  en_i           in   1             one statistics beat of N_PIX pixels
//  slow_div       in   SLOW_DIV_LEN  en_slow period minus 1
//  start_rdy      out  1             stats FSM idle
//  en_slow        out  1             decision-pace strobe
//  stat_active    out  1             en_i beats counted this cycle
//  cIdx           out  2             component under statistics
//  cnt_st         out  CNT_ST_LEN    beat index within component
//  dc_active      out  1             decision running
//  cIdx_dc        out  2             component under decision
//  cnt_dc         out  CNT_DC_LEN    strobe index within component
//  wait_forPre    out  1             stats done, waiting for previous decision
//  ctu_done       out  1             1-cycle pulse, CTU decision complete
// BEHAVIOUR
//  Reset: all outputs, counters and FSMs 0/idle. start_rdy = (stats FSM == ST_IDLE), so 1 in reset.
//  arst mid-operation aborts both phases; no ctu_done is produced.
//  Size: L = clamp(ctb_size_log2, MIN, MAX). Beats per comp: luma 2^(2L)/N_PIX; chroma 2^(2L-2)/N_PIX.
//  en_slow: free-running divider, div counts 0..slow_div; en_slow=1 when div==slow_div, then div<=0.
//   If div>slow_div (slow_div lowered), div<=0 next cycle with no strobe. slow_div=0 -> strobe every cycle.
//  Stats FSM ST_IDLE/ST_RUN/ST_WAIT:
//   ST_IDLE & start_ctu -> ST_RUN; cIdx=0, cnt_st=0, L latched. start_ctu in other states ignored.
//   ST_RUN: stat_active=1; en_i -> cnt_st++. On last beat: if cIdx<N_COMP-1, cIdx++, cnt_st=0;
//    else handoff if decision idle or finishing this cycle -> ST_IDLE, else -> ST_WAIT.
//   ST_WAIT: wait_forPre=1, stat_active=0, en_i ignored; on decision finish -> handoff, ST_IDLE.
//  Decision FSM DC_IDLE/DC_RUN: handoff -> DC_RUN next cycle, cIdx_dc=0, cnt_dc=0.
//   Each en_slow: cnt_dc++. At cnt_dc==DC_CYCLES-1 & en_slow: next comp (cnt_dc=0), or after last comp
//   -> DC_IDLE, ctu_done=1 next cycle (same cycle dc_active drops), unless handoff restarts DC_RUN.
//  Simultaneous final stat beat and final decision strobe: handoff without ST_WAIT, no bubble.
//  Both FSMs may be active together (pipelining). Nothing held across CTUs except the divider.
// TESTING
//  1 arst asserted mid ST_RUN, cnt_st=100 -> all outputs 0 same cycle, start_rdy=1, no ctu_done.
//  2 L=4, N_PIX=8, slow_div=0, continuous en_i -> cIdx 0/1/2 for 32/8/8 beats, dc_active next cycle,
//    cIdx_dc steps every 36 cycles, ctu_done 109 cycles after handoff.
//  3 L=6, slow_div=7, back-to-back CTUs, continuous en_i -> stats 768 beats vs decision 864 cycles;
//    wait_forPre high 96+-2 cycles, en_i ignored then, cnt_st frozen.
//  4 final stat beat aligned with final decision strobe -> wait_forPre never 1, ctu_done pulses,
//    dc_active stays 1 with cIdx_dc=0, cnt_dc=0 next cycle.
//  5 slow_div 7->2 at div=5 -> no strobe, div=0 next cycle, then en_slow every 3rd cycle.
//  6 start_ctu pulsed during ST_RUN/ST_WAIT -> ignored, start_rdy=0, counters unchanged.

Source files
------------

// File: rtl/sao_ctu_sched.sv
// SAO CTU scheduler: statistics phase (pixel-beat counted) pipelined against the
// offset-decision phase (paced by a programmable slow strobe) on a single clock.
module sao_ctu_sched #(
    parameter int N_PIX        = 8,
    parameter int N_COMP       = 3,
    parameter int MIN_CTB_LOG2 = 4,
    parameter int MAX_CTB_LOG2 = 6,
    parameter int CNT_ST_LEN   = 10,
    parameter int CNT_DC_LEN   = 6,
    parameter int DC_CYCLES    = 36,
    parameter int SLOW_DIV_LEN = 3
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    start_ctu,
    input  logic [2:0]              ctb_size_log2,
    input  logic                    en_i,
    input  logic [SLOW_DIV_LEN-1:0] slow_div,
    output logic                    start_rdy,
    output logic                    en_slow,
    output logic                    stat_active,
    output logic [1:0]              cIdx,
    output logic [CNT_ST_LEN-1:0]   cnt_st,
    output logic                    dc_active,
    output logic [1:0]              cIdx_dc,
    output logic [CNT_DC_LEN-1:0]   cnt_dc,
    output logic                    wait_forPre,
    output logic                    ctu_done
);

    localparam int PIX_LOG2 = $clog2(N_PIX);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT} st_state_t;
    typedef enum logic       {DC_IDLE, DC_RUN}          dc_state_t;

    st_state_t               st_state;
    dc_state_t               dc_state;
    logic [SLOW_DIV_LEN-1:0] div;
    logic [2:0]              ctb_l;
    logic [2:0]              ctb_l_in;
    logic [4:0]              beat_sh;
    logic [CNT_ST_LEN-1:0]   last_beat;
    logic                    beat_last;
    logic                    comp_last;
    logic                    dc_step_last;
    logic                    dc_fin;
    logic                    handoff;

    always_comb begin
        ctb_l_in = ctb_size_log2;
        if (ctb_size_log2 < 3'(MIN_CTB_LOG2))
            ctb_l_in = 3'(MIN_CTB_LOG2);
        else if (ctb_size_log2 > 3'(MAX_CTB_LOG2))
            ctb_l_in = 3'(MAX_CTB_LOG2);
    end

    // Beats per component: 2^(2L)/N_PIX for luma, a quarter of that for chroma.
    always_comb begin
        beat_sh   = {1'b0, ctb_l, 1'b0} - 5'(PIX_LOG2) - ((cIdx == 2'd0) ? 5'd0 : 5'd2);
        last_beat = CNT_ST_LEN'((32'd1 << beat_sh) - 32'd1);
    end

    assign comp_last    = (cIdx == 2'(N_COMP - 1));
    assign beat_last    = (st_state == ST_RUN) && en_i && (cnt_st == last_beat);
    assign dc_step_last = (cnt_dc == CNT_DC_LEN'(DC_CYCLES - 1));
    assign dc_fin       = (dc_state == DC_RUN) && en_slow && dc_step_last &&
                          (cIdx_dc == 2'(N_COMP - 1));
    // A finishing decision frees the slot in the same cycle, so no wait bubble.
    assign handoff      = (beat_last && comp_last && ((dc_state == DC_IDLE) || dc_fin)) ||
                          ((st_state == ST_WAIT) && dc_fin);
    assign start_rdy    = (st_state == ST_IDLE);

    // Free-running pace divider; a lowered slow_div restarts it without a strobe.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            div     <= '0;
            en_slow <= 1'b0;
        end else if (div == slow_div) begin
            div     <= '0;
            en_slow <= 1'b1;
        end else if (div > slow_div) begin
            div     <= '0;
            en_slow <= 1'b0;
        end else begin
            div     <= div + SLOW_DIV_LEN'(1);
            en_slow <= 1'b0;
        end
    end

    // NOTE: all state, including registered outputs, updates with <= so every
    // process samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            st_state    <= ST_IDLE;
            cIdx        <= '0;
            cnt_st      <= '0;
            ctb_l       <= '0;
            stat_active <= 1'b0;
            wait_forPre <= 1'b0;
        end else begin
            case (st_state)
                ST_IDLE: if (start_ctu) begin
                    st_state    <= ST_RUN;
                    stat_active <= 1'b1;
                    cIdx        <= '0;
                    cnt_st      <= '0;
                    ctb_l       <= ctb_l_in;
                end
                ST_RUN: if (en_i) begin
                    if (cnt_st != last_beat) begin
                        cnt_st <= cnt_st + CNT_ST_LEN'(1);
                    end else if (!comp_last) begin
                        cIdx   <= cIdx + 2'd1;
                        cnt_st <= '0;
                    end else if (handoff) begin
                        st_state    <= ST_IDLE;
                        stat_active <= 1'b0;
                    end else begin
                        st_state    <= ST_WAIT;
                        stat_active <= 1'b0;
                        wait_forPre <= 1'b1;
                    end
                end
                ST_WAIT: if (dc_fin) begin
                    st_state    <= ST_IDLE;
                    wait_forPre <= 1'b0;
                end
                default: st_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dc_state  <= DC_IDLE;
            dc_active <= 1'b0;
            cIdx_dc   <= '0;
            cnt_dc    <= '0;
            ctu_done  <= 1'b0;
        end else begin
            ctu_done <= dc_fin;
            if (handoff) begin
                dc_state  <= DC_RUN;
                dc_active <= 1'b1;
                cIdx_dc   <= '0;
                cnt_dc    <= '0;
            end else if ((dc_state == DC_RUN) && en_slow) begin
                if (!dc_step_last) begin
                    cnt_dc <= cnt_dc + CNT_DC_LEN'(1);
                end else if (dc_fin) begin
                    dc_state  <= DC_IDLE;
                    dc_active <= 1'b0;
                    cIdx_dc   <= '0;
                    cnt_dc    <= '0;
                end else begin
                    cIdx_dc <= cIdx_dc + 2'd1;
                    cnt_dc  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sao_ctu_sched.sv
// Bench for sao_ctu_sched: directed scenarios plus random traffic, every cycle
// compared against a flat-index reference model of the scheduler.
module tb_sao_ctu_sched;

    localparam int N_PIX        = 8;
    localparam int N_COMP       = 3;
    localparam int MIN_CTB_LOG2 = 4;
    localparam int MAX_CTB_LOG2 = 6;
    localparam int CNT_ST_LEN   = 10;
    localparam int CNT_DC_LEN   = 6;
    localparam int DC_CYCLES    = 36;
    localparam int SLOW_DIV_LEN = 3;
    localparam int DC_TOTAL     = N_COMP * DC_CYCLES;

    logic                    clk = 1'b0;
    logic                    arst;
    logic                    start_ctu;
    logic [2:0]              ctb_size_log2;
    logic                    en_i;
    logic [SLOW_DIV_LEN-1:0] slow_div;
    logic                    start_rdy;
    logic                    en_slow;
    logic                    stat_active;
    logic [1:0]              cIdx;
    logic [CNT_ST_LEN-1:0]   cnt_st;
    logic                    dc_active;
    logic [1:0]              cIdx_dc;
    logic [CNT_DC_LEN-1:0]   cnt_dc;
    logic                    wait_forPre;
    logic                    ctu_done;

    sao_ctu_sched #(
        .N_PIX(N_PIX), .N_COMP(N_COMP), .MIN_CTB_LOG2(MIN_CTB_LOG2),
        .MAX_CTB_LOG2(MAX_CTB_LOG2), .CNT_ST_LEN(CNT_ST_LEN), .CNT_DC_LEN(CNT_DC_LEN),
        .DC_CYCLES(DC_CYCLES), .SLOW_DIV_LEN(SLOW_DIV_LEN)
    ) dut (
        .clk(clk), .arst(arst), .start_ctu(start_ctu), .ctb_size_log2(ctb_size_log2),
        .en_i(en_i), .slow_div(slow_div), .start_rdy(start_rdy), .en_slow(en_slow),
        .stat_active(stat_active), .cIdx(cIdx), .cnt_st(cnt_st), .dc_active(dc_active),
        .cIdx_dc(cIdx_dc), .cnt_dc(cnt_dc), .wait_forPre(wait_forPre), .ctu_done(ctu_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: stats progress is a flat beat index over the whole CTU,
    // decision progress a flat strobe index; component/offset are derived.
    int m_st;       // 0 idle, 1 run, 2 wait
    int m_beat;
    int m_L;
    int m_dc;
    int m_strobe;
    int m_div;
    int m_en_slow;
    int m_done;

    function automatic int clamp_l(input int v);
        if (v < MIN_CTB_LOG2) return MIN_CTB_LOG2;
        if (v > MAX_CTB_LOG2) return MAX_CTB_LOG2;
        return v;
    endfunction

    function automatic int luma_n(input int l);
        return (1 << (2 * l)) / N_PIX;
    endfunction

    function automatic int total_n(input int l);
        return luma_n(l) + (N_COMP - 1) * (luma_n(l) / 4);
    endfunction

    function automatic int exp_cidx();
        if (m_beat < luma_n(m_L)) return 0;
        return 1 + (m_beat - luma_n(m_L)) / (luma_n(m_L) / 4);
    endfunction

    function automatic int exp_cnt_st();
        if (m_beat < luma_n(m_L)) return m_beat;
        return (m_beat - luma_n(m_L)) % (luma_n(m_L) / 4);
    endfunction

    task automatic model_reset();
        m_st = 0; m_beat = 0; m_L = MIN_CTB_LOG2;
        m_dc = 0; m_strobe = 0; m_div = 0; m_en_slow = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit fin, last, hand;
        if (arst) begin
            model_reset();
            return;
        end
        fin  = (m_dc != 0) && (m_en_slow != 0) && (m_strobe == DC_TOTAL - 1);
        last = (m_st == 1) && en_i && (m_beat == total_n(m_L) - 1);
        hand = (last && (m_dc == 0 || fin)) || (m_st == 2 && fin);
        m_done = fin;
        if (m_dc != 0 && m_en_slow != 0) begin
            if (fin) begin m_dc = 0; m_strobe = 0; end
            else m_strobe++;
        end
        if (hand) begin m_dc = 1; m_strobe = 0; end
        case (m_st)
            0: if (start_ctu) begin m_st = 1; m_beat = 0; m_L = clamp_l(int'(ctb_size_log2)); end
            1: if (en_i) begin
                   if (last) m_st = hand ? 0 : 2;
                   else m_beat++;
               end
            default: if (fin) m_st = 0;
        endcase
        if (m_div == int'(slow_div)) begin m_div = 0; m_en_slow = 1; end
        else if (m_div > int'(slow_div)) begin m_div = 0; m_en_slow = 0; end
        else begin m_div++; m_en_slow = 0; end
    endtask

    task automatic compare_all();
        check("start_rdy",   start_rdy,   m_st == 0);
        check("stat_active", stat_active, m_st == 1);
        check("wait_forPre", wait_forPre, m_st == 2);
        check("cIdx",        cIdx,        exp_cidx());
        check("cnt_st",      cnt_st,      exp_cnt_st());
        check("dc_active",   dc_active,   m_dc);
        check("cIdx_dc",     cIdx_dc,     m_strobe / DC_CYCLES);
        check("cnt_dc",      cnt_dc,      m_strobe % DC_CYCLES);
        check("en_slow",     en_slow,     m_en_slow);
        check("ctu_done",    ctu_done,    m_done);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    int n;
    int wait_dut;
    int wait_mod;
    int done_cnt;
    logic [6:0] pat;

    initial begin
        arst = 1'b1; start_ctu = 1'b0; ctb_size_log2 = 3'd4; en_i = 1'b0; slow_div = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        arst = 1'b0;

        // Smallest CTB, strobe every cycle: 32/8/8 beats then 108-strobe decision.
        en_i = 1'b1; start_ctu = 1'b1;
        tick();
        start_ctu = 1'b0;
        n = 0;
        while (!dc_active && n < 200) begin tick(); n++; end
        check("t2_stats_len", n, 48);
        n = 0;
        while (!ctu_done && n < 300) begin tick(); n++; end
        check("t2_dc_len", n, 108);
        tick();

        // Reset mid statistics at cnt_st=100.
        ctb_size_log2 = 3'd6; start_ctu = 1'b1;
        tick();
        start_ctu = 1'b0;
        n = 0;
        while (!(m_st == 1 && m_beat == 100) && n < 200) begin tick(); n++; end
        check("t1_reach", cnt_st, 100);
        #2 arst = 1'b1;
        #1;
        check("t1_start_rdy", start_rdy, 1);
        check("t1_stat",      stat_active, 0);
        check("t1_cnt_st",    cnt_st, 0);
        check("t1_en_slow",   en_slow, 0);
        check("t1_dc",        dc_active, 0);
        check("t1_done",      ctu_done, 0);
        model_reset();
        tick();
        arst = 1'b0;
        repeat (20) tick();

        // Final stat beat aligned with final decision strobe.
        slow_div = '0; ctb_size_log2 = 3'd2; start_ctu = 1'b1; en_i = 1'b1;
        tick();
        start_ctu = 1'b0;
        n = 0;
        while (m_dc == 0 && n < 200) begin tick(); n++; end
        start_ctu = 1'b1;
        tick();
        start_ctu = 1'b0;
        wait_dut = 0; n = 0;
        while (m_st != 0 && n < 300) begin
            en_i = (m_beat < total_n(m_L) - 1) ||
                   (m_dc != 0 && m_en_slow != 0 && m_strobe == DC_TOTAL - 1);
            tick();
            if (wait_forPre) wait_dut++;
            n++;
        end
        check("t4_no_wait", wait_dut, 0);
        check("t4_done",    ctu_done, 1);
        check("t4_dc",      dc_active, 1);
        check("t4_cidx_dc", cIdx_dc, 0);
        check("t4_cnt_dc",  cnt_dc, 0);
        en_i = 1'b0;
        n = 0;
        while (dc_active && n < 300) begin tick(); n++; end
        check("t4_drain", dc_active, 0);

        // Divider period lowered while div is above the new limit.
        slow_div = 3'd7;
        n = 0;
        while (m_div != 5 && n < 20) begin tick(); n++; end
        slow_div = 3'd2;
        for (int i = 0; i < 7; i++) begin tick(); pat[i] = en_slow; end
        check("t5_pattern", pat, 7'b1001000);

        // Largest CTB, slow decision, back-to-back CTUs with start_ctu held high.
        slow_div = 3'd7; ctb_size_log2 = 3'd6; en_i = 1'b1; start_ctu = 1'b1;
        done_cnt = 0; wait_dut = 0; wait_mod = 0; n = 0;
        while (done_cnt < 3 && n < 5000) begin
            tick();
            if (ctu_done) done_cnt++;
            if (m_st == 2) wait_mod++;
            if (wait_forPre) begin
                wait_dut++;
                check("t3_frozen", cnt_st, 127);
            end
            n++;
        end
        check("t3_ctus",      done_cnt, 3);
        check("t3_wait_seen", wait_dut > 80, 1);
        check("t3_wait_len",  wait_dut, wait_mod);
        start_ctu = 1'b0; en_i = 1'b0;
        n = 0;
        while ((dc_active || !start_rdy) && n < 3000) begin tick(); n++; end

        // Random traffic.
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(0, 499) == 0) slow_div = SLOW_DIV_LEN'($urandom_range(0, 7));
            start_ctu     = ($urandom_range(0, 7) == 0);
            ctb_size_log2 = 3'($urandom_range(0, 7));
            en_i          = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
